// File: rtl/memory_access.sv
// Memory stage: one req/ack data access per load/store, MEM/WB register.
// Optional: define MEM_ALIGN_CHECK_EN to fault misaligned accesses.
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ExMe_out_valid,
  input  logic        ExMe_out_mem_en,
  input  logic        ExMe_out_mem_wrt,
  input  logic        ExMe_out_reg_wrt_en,
  input  logic [1:0]  ExMe_out_result_sel,
  input  logic [31:0] ExMe_out_alu_out,
  input  logic [31:0] ExMe_out_reg_2,
  input  logic [31:0] ExMe_out_LR,
  input  logic [1:0]  ExMe_out_FL,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_mem,
  output logic        mem_fault,
  output logic        MeWb_out_valid,
  output logic        MeWb_out_reg_wrt_en,
  output logic [1:0]  MeWb_out_result_sel,
  output logic [31:0] MeWb_out_mem_data,
  output logic [31:0] MeWb_out_alu_out,
  output logic [31:0] MeWb_out_LR,
  output logic [1:0]  MeWb_out_FL
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] cnt;
  logic        kill;
  logic [31:0] rdata_q;
  logic        op;
  logic        misal;
  logic        tmo;
  logic        is_load;

  // Decode the live request and pick the next state and stall.
  always_comb begin
    op       = ExMe_out_valid & ExMe_out_mem_en & ~flush;
    is_load  = ExMe_out_mem_en & ~ExMe_out_mem_wrt;
`ifdef MEM_ALIGN_CHECK_EN
    misal    = (ExMe_out_alu_out[1:0] != 2'b00);
`else
    misal    = 1'b0;
`endif
    tmo      = (cnt == TMO_LAST);
    state_nx = state;
    stall_mem = 1'b0;
    unique case (state)
      IDLE: begin
        if (op) begin
          stall_mem = 1'b1;
          state_nx  = misal ? DONE : REQ;
        end
      end
      REQ: begin
        stall_mem = 1'b1;
        if (mem_ack || tmo) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Bus request, timeout, kill tracking and the MEM/WB register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req             <= 1'b0;
      mem_we              <= 1'b0;
      mem_addr            <= '0;
      mem_wdata           <= '0;
      mem_fault           <= 1'b0;
      cnt                 <= '0;
      kill                <= 1'b0;
      rdata_q             <= '0;
      MeWb_out_valid      <= 1'b0;
      MeWb_out_reg_wrt_en <= 1'b0;
      MeWb_out_result_sel <= '0;
      MeWb_out_mem_data   <= '0;
      MeWb_out_alu_out    <= '0;
      MeWb_out_LR         <= '0;
      MeWb_out_FL         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (op) begin
            cnt       <= '0;
            kill      <= misal;
            mem_fault <= mem_fault | misal;
            if (!misal) begin
              mem_req   <= 1'b1;
              mem_we    <= ExMe_out_mem_wrt;
              mem_addr  <= {ExMe_out_alu_out[31:2], 2'b00};
              mem_wdata <= ExMe_out_reg_2;
            end
          end else begin
            MeWb_out_valid      <= ExMe_out_valid & ~flush;
            MeWb_out_reg_wrt_en <= ExMe_out_reg_wrt_en;
            MeWb_out_result_sel <= ExMe_out_result_sel;
            MeWb_out_alu_out    <= ExMe_out_alu_out;
            MeWb_out_LR         <= ExMe_out_LR;
            MeWb_out_FL         <= ExMe_out_FL;
          end
        end
        REQ: begin
          if (flush) kill <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) rdata_q <= mem_rdata;
          end else if (tmo) begin
            mem_req   <= 1'b0;
            mem_fault <= 1'b1;
            kill      <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          MeWb_out_valid      <= ~kill & ~flush;
          MeWb_out_reg_wrt_en <= ExMe_out_reg_wrt_en & ~kill & ~flush;
          MeWb_out_result_sel <= ExMe_out_result_sel;
          MeWb_out_alu_out    <= ExMe_out_alu_out;
          MeWb_out_LR         <= ExMe_out_LR;
          MeWb_out_FL         <= ExMe_out_FL;
          if (is_load) MeWb_out_mem_data <= rdata_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access (TIMEOUT_CYCLES = 4).
// Align-check step follows MEM_ALIGN_CHECK_EN.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ExMe_out_valid;
  logic        ExMe_out_mem_en;
  logic        ExMe_out_mem_wrt;
  logic        ExMe_out_reg_wrt_en;
  logic [1:0]  ExMe_out_result_sel;
  logic [31:0] ExMe_out_alu_out;
  logic [31:0] ExMe_out_reg_2;
  logic [31:0] ExMe_out_LR;
  logic [1:0]  ExMe_out_FL;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_mem;
  logic        mem_fault;
  logic        MeWb_out_valid;
  logic        MeWb_out_reg_wrt_en;
  logic [1:0]  MeWb_out_result_sel;
  logic [31:0] MeWb_out_mem_data;
  logic [31:0] MeWb_out_alu_out;
  logic [31:0] MeWb_out_LR;
  logic [1:0]  MeWb_out_FL;

  int vectors = 0;
  int errors  = 0;

  memory_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ExMe_out_valid      (ExMe_out_valid),
    .ExMe_out_mem_en     (ExMe_out_mem_en),
    .ExMe_out_mem_wrt    (ExMe_out_mem_wrt),
    .ExMe_out_reg_wrt_en (ExMe_out_reg_wrt_en),
    .ExMe_out_result_sel (ExMe_out_result_sel),
    .ExMe_out_alu_out    (ExMe_out_alu_out),
    .ExMe_out_reg_2      (ExMe_out_reg_2),
    .ExMe_out_LR         (ExMe_out_LR),
    .ExMe_out_FL         (ExMe_out_FL),
    .flush               (flush),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_ack             (mem_ack),
    .mem_rdata           (mem_rdata),
    .stall_mem           (stall_mem),
    .mem_fault           (mem_fault),
    .MeWb_out_valid      (MeWb_out_valid),
    .MeWb_out_reg_wrt_en (MeWb_out_reg_wrt_en),
    .MeWb_out_result_sel (MeWb_out_result_sel),
    .MeWb_out_mem_data   (MeWb_out_mem_data),
    .MeWb_out_alu_out    (MeWb_out_alu_out),
    .MeWb_out_LR         (MeWb_out_LR),
    .MeWb_out_FL         (MeWb_out_FL)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic v, input logic en, input logic wr,
                        input logic rw, input logic [31:0] a,
                        input logic [31:0] d);
    ExMe_out_valid      = v;
    ExMe_out_mem_en     = en;
    ExMe_out_mem_wrt    = wr;
    ExMe_out_reg_wrt_en = rw;
    ExMe_out_alu_out    = a;
    ExMe_out_reg_2      = d;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_op(0, 0, 0, 0, 32'h0, 32'h0);
    ExMe_out_result_sel = 2'd0;
    ExMe_out_LR = 32'h0;
    ExMe_out_FL = 2'd0;
    flush = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    #12;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("rst_fault", {31'd0, mem_fault}, 32'd0);
    chk("rst_valid", {31'd0, MeWb_out_valid}, 32'd0);
    chk("rst_alu", MeWb_out_alu_out, 32'd0);
    chk("rst_mdata", MeWb_out_mem_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU pass-through
    set_op(1, 0, 0, 1, 32'h0000_1234, 32'h0);
    ExMe_out_result_sel = 2'd1;
    ExMe_out_LR = 32'h55;
    ExMe_out_FL = 2'b10;
    #1;
    chk("alu_stall", {31'd0, stall_mem}, 32'd0);
    tick();
    chk("alu_valid", {31'd0, MeWb_out_valid}, 32'd1);
    chk("alu_out", MeWb_out_alu_out, 32'h1234);
    chk("alu_rwe", {31'd0, MeWb_out_reg_wrt_en}, 32'd1);
    chk("alu_sel", {30'd0, MeWb_out_result_sel}, 32'd1);
    chk("alu_lr", MeWb_out_LR, 32'h55);
    chk("alu_fl", {30'd0, MeWb_out_FL}, 32'd2);
    chk("alu_req", {31'd0, mem_req}, 32'd0);

    // flushed ALU op becomes a bubble
    flush = 1'b1;
    ExMe_out_alu_out = 32'h9;
    tick();
    flush = 1'b0;
    chk("flush_alu_valid", {31'd0, MeWb_out_valid}, 32'd0);

    // load 0x100, ack in the 3rd REQ cycle
    set_op(1, 1, 0, 1, 32'h100, 32'h0);
    ExMe_out_result_sel = 2'd2;
    #1;
    chk("ld_stall1", {31'd0, stall_mem}, 32'd1);
    chk("ld_noreq0", {31'd0, mem_req}, 32'd0);
    tick();
    chk("ld_req", {31'd0, mem_req}, 32'd1);
    chk("ld_addr1", mem_addr, 32'h100);
    chk("ld_we", {31'd0, mem_we}, 32'd0);
    chk("ld_stall2", {31'd0, stall_mem}, 32'd1);
    tick();
    chk("ld_stall3", {31'd0, stall_mem}, 32'd1);
    chk("ld_addr2", mem_addr, 32'h100);
    tick();
    chk("ld_stall4", {31'd0, stall_mem}, 32'd1);
    chk("ld_addr3", mem_addr, 32'h100);
    chk("ld_req3", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    chk("ld_done_stall", {31'd0, stall_mem}, 32'd0);
    chk("ld_done_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("ld_valid", {31'd0, MeWb_out_valid}, 32'd1);
    chk("ld_data", MeWb_out_mem_data, 32'hDEAD_BEEF);
    chk("ld_rwe", {31'd0, MeWb_out_reg_wrt_en}, 32'd1);
    chk("ld_alu", MeWb_out_alu_out, 32'h100);

    // store 0x204, ack in first REQ cycle
    set_op(1, 1, 1, 0, 32'h204, 32'hCAFE_0001);
    #1;
    chk("st_stall1", {31'd0, stall_mem}, 32'd1);
    tick();
    chk("st_req", {31'd0, mem_req}, 32'd1);
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_wdata", mem_wdata, 32'hCAFE_0001);
    chk("st_addr", mem_addr, 32'h204);
    chk("st_stall2", {31'd0, stall_mem}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("st_done_stall", {31'd0, stall_mem}, 32'd0);
    chk("st_done_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("st_valid", {31'd0, MeWb_out_valid}, 32'd1);
    chk("st_rwe", {31'd0, MeWb_out_reg_wrt_en}, 32'd0);
    chk("st_mdata_kept", MeWb_out_mem_data, 32'hDEAD_BEEF);

    // flush in 2nd REQ cycle, ack in 3rd
    set_op(1, 1, 0, 1, 32'h300, 32'h0);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_req_held", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h1111;
    tick();
    mem_ack = 1'b0;
    chk("fl_done_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("fl_valid", {31'd0, MeWb_out_valid}, 32'd0);
    chk("fl_rwe", {31'd0, MeWb_out_reg_wrt_en}, 32'd0);
    chk("fl_fault", {31'd0, mem_fault}, 32'd0);

    // misaligned load 0x102
    set_op(1, 1, 0, 1, 32'h102, 32'h0);
    mem_rdata = 32'h77;
`ifdef MEM_ALIGN_CHECK_EN
    #1;
    chk("al_stall1", {31'd0, stall_mem}, 32'd1);
    tick();
    chk("al_noreq", {31'd0, mem_req}, 32'd0);
    chk("al_fault", {31'd0, mem_fault}, 32'd1);
    chk("al_done_stall", {31'd0, stall_mem}, 32'd0);
    tick();
    chk("al_valid", {31'd0, MeWb_out_valid}, 32'd0);
`else
    tick();
    chk("al_addr", mem_addr, 32'h100);
    chk("al_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("al_data", MeWb_out_mem_data, 32'h77);
    chk("al_valid", {31'd0, MeWb_out_valid}, 32'd1);
    chk("al_fault", {31'd0, mem_fault}, 32'd0);
`endif

    // timeout: 4 REQ cycles with no ack
    set_op(1, 1, 0, 1, 32'h400, 32'h0);
    tick();
    chk("to_req1", {31'd0, mem_req}, 32'd1);
    tick();
    tick();
    tick();
    chk("to_req4", {31'd0, mem_req}, 32'd1);
    chk("to_stall4", {31'd0, stall_mem}, 32'd1);
    tick();
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_fault", {31'd0, mem_fault}, 32'd1);
    chk("to_done_stall", {31'd0, stall_mem}, 32'd0);
    tick();
    set_op(0, 0, 0, 0, 32'h0, 32'h0);
    chk("to_valid", {31'd0, MeWb_out_valid}, 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("to_late_ack", {31'd0, mem_req}, 32'd0);
    chk("to_fault_sticky", {31'd0, mem_fault}, 32'd1);

    // reset while a request is outstanding
    set_op(1, 1, 0, 1, 32'h500, 32'h0);
    tick();
    chk("rr_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rr_fault_clr", {31'd0, mem_fault}, 32'd0);
    set_op(0, 0, 0, 0, 32'h0, 32'h0);
    mem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rr_ack_ignored", {31'd0, mem_req}, 32'd0);
    chk("rr_stall", {31'd0, stall_mem}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
